hps_design_pio_ext: RTL and testbench
=====================================

HPS_DESIGN_PIO_EXT -- requirements
Module: hps_design_pio_ext

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, number of PIO bits (1..32).
REQ-002 SHALL provide parameter RESET_VALUE, default 0, reset value of the output data register (WIDTH bits).
REQ-003 SHALL provide parameter EDGE_TYPE, default 0, capture edge: 0 rising, 1 falling, 2 any.
REQ-004 SHALL provide parameter IRQ_MODE, default 1, 0 level-sensitive, 1 edge-capture.
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port address  input  3  register select.
REQ-008 SHALL have port chipselect  input  1  slave select.
REQ-009 SHALL have port write_n  input  1  active-low write strobe.
REQ-010 SHALL have port writedata  input  32  write data; bits above WIDTH ignored.
REQ-011 SHALL have port readdata  output  32  read data; bits above WIDTH zero.
REQ-012 SHALL have port in_port  input  WIDTH  asynchronous pin inputs.
REQ-013 SHALL have port out_port  output  WIDTH  output data register.
REQ-014 SHALL have port out_en  output  WIDTH  per-bit drive enable (= direction register).
REQ-015 SHALL have port irq  output  1  interrupt request.

Function
REQ-016 SHALL decode write = chipselect & ~write_n; register map: 0 data, 1 direction, 2 irqmask, 3 edgecapture, 4 outset, 5 outclear, 6-7 reserved.
REQ-017 SHALL pass in_port through a 2-flop synchronizer (in_s); edge detection SHALL compare in_s with a third flop in_d.
REQ-018 SHALL define edge(i): rising = in_s & ~in_d; falling = ~in_s & in_d; any = in_s ^ in_d, per EDGE_TYPE.
REQ-019 Write to address 0 SHALL load data_out from writedata[WIDTH-1:0] next cycle.
REQ-020 Write to address 4 SHALL set data_out bits where writedata is 1; address 5 SHALL clear them; other bits unchanged.
REQ-021 Write to address 1 SHALL load direction; address 2 SHALL load irqmask.
REQ-022 edgecapture bit i SHALL set when edge(i) and direction(i)=0; write to address 3 SHALL clear bits where writedata is 1 (write-1-to-clear).
REQ-023 Same-cycle edge and clear on one bit: set SHALL win (bit remains 1).
REQ-024 readdata SHALL be combinational (zero wait states): addr 0 = (direction & data_out) | (~direction & in_s); 1 direction; 2 irqmask; 3 edgecapture; 4-7 zero.
REQ-025 readdata SHALL be zero when chipselect is 0.
REQ-026 IRQ_MODE=1: irq SHALL be registered |(edgecapture & irqmask), asserting one cycle after the capture bit sets.
REQ-027 IRQ_MODE=0: irq SHALL be registered |(in_s & ~direction & irqmask).
REQ-028 Writes to reserved addresses 6-7 SHALL have no effect.
REQ-029 Input-pin-to-edgecapture latency SHALL be 3 cycles (2 sync + capture); pin-to-irq 4 cycles in edge mode.

Reset
REQ-030 On reset=1 at a clk edge: data_out=RESET_VALUE, direction=0, irqmask=0, edgecapture=0, irq=0, synchronizer and in_d flops=0.
REQ-031 Reset SHALL override any same-cycle write or edge.
REQ-032 Edges detected in the first cycle after reset release from the zeroed synchronizer SHALL be captured normally (no masking).

Verification
REQ-033 WIDTH=8: reset, read addr 0-3 -> 0x00 each (RESET_VALUE=0), out_en=0x00, irq=0.
REQ-034 write dir=0xFF, data=0x5A, outset=0x81, outclear=0x02 -> out_port=0xD9, read addr 0 = 0xD9.
REQ-035 dir=0x00, mask=0x01, EDGE_TYPE=0, in_port[0] 0->1 -> edgecapture=0x01 after 3 cycles, irq=1 one cycle later; write 0x01 to addr 3 -> irq=0.
REQ-036 edge on bit 2 coincident with clear write 0x04 to addr 3 -> edgecapture bit 2 stays 1.
REQ-037 assert reset mid-operation with data_out=0xFF, edgecapture=0x0F -> next cycle all registers at reset values, irq=0.
REQ-038 IRQ_MODE=0, mask=0x10, in_port[4]=1 held -> irq=1 after 3 cycles; deassert pin -> irq=0 after 3 cycles.

Source files
------------

// File: rtl/hps_design_pio_ext_if.sv
// hps_design_pio_ext_if: register-bus signals between a PIO master and the PIO slave.
interface hps_design_pio_ext_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/hps_design_pio_ext.sv
// hps_design_pio_ext: bidirectional PIO with edge capture, interrupt mask and set/clear output access.
module hps_design_pio_ext #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               EDGE_TYPE   = 0,
    parameter int               IRQ_MODE    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    hps_design_pio_ext_if.slave     bus,
    input  logic [WIDTH-1:0]        in_port,
    output logic [WIDTH-1:0]        out_port,
    output logic [WIDTH-1:0]        out_en,
    output logic                    irq
);
    logic             wr;
    logic [WIDTH-1:0] wd, edge_v, rd_v;
    logic [WIDTH-1:0] sync_q, in_s_q, in_d_q;
    logic [WIDTH-1:0] data_q, data_d, dir_q, dir_d, mask_q, mask_d, cap_q, cap_d;
    logic             irq_q, irq_d;
    logic             unused;
    assign wr     = bus.chipselect & ~bus.write_n;
    assign wd     = bus.writedata[WIDTH-1:0];
    assign unused = ^bus.writedata;
    always_comb begin
        edge_v = EDGE_TYPE == 0 ? in_s_q & ~in_d_q :
                 EDGE_TYPE == 1 ? ~in_s_q & in_d_q : in_s_q ^ in_d_q;
        data_d = !wr                   ? data_q :
                 bus.address == 3'd0   ? wd :
                 bus.address == 3'd4   ? data_q | wd :
                 bus.address == 3'd5   ? data_q & ~wd : data_q;
        dir_d  = wr && bus.address == 3'd1 ? wd : dir_q;
        mask_d = wr && bus.address == 3'd2 ? wd : mask_q;
        // a new edge is OR-ed in after the clear so capture wins a same-cycle race
        cap_d  = (cap_q & ~(wr && bus.address == 3'd3 ? wd : '0)) | (edge_v & ~dir_q);
        irq_d  = IRQ_MODE == 1 ? |(cap_q & mask_q) : |(in_s_q & ~dir_q & mask_q);
        rd_v   = bus.address == 3'd0 ? (dir_q & data_q) | (~dir_q & in_s_q) :
                 bus.address == 3'd1 ? dir_q :
                 bus.address == 3'd2 ? mask_q :
                 bus.address == 3'd3 ? cap_q : '0;
        bus.readdata = bus.chipselect ? 32'(rd_v) : '0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            in_s_q <= '0;
            in_d_q <= '0;
            data_q <= RESET_VALUE;
            dir_q  <= '0;
            mask_q <= '0;
            cap_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            sync_q <= in_port;
            in_s_q <= sync_q;
            in_d_q <= in_s_q;
            data_q <= data_d;
            dir_q  <= dir_d;
            mask_q <= mask_d;
            cap_q  <= cap_d;
            irq_q  <= irq_d;
        end
    end
    assign out_port = data_q;
    assign out_en   = dir_q;
    assign irq      = irq_q;
endmodule

// File: tb/tb_hps_design_pio_ext.sv
// tb_hps_design_pio_ext: two PIO variants (edge/rising/RV=0 and level/falling/RV=A5) against a bench model.
module tb_hps_design_pio_ext;
    logic        clk = 0, reset = 1;
    logic [2:0]  address = 0;
    logic        chipselect = 0, write_n = 1;
    logic [31:0] writedata = 0;
    logic [7:0]  in_port = 0;
    logic [7:0]  out_a, oe_a, out_b, oe_b;
    logic        irq_a, irq_b;
    int          n_cmp = 0, n_bad = 0;
    hps_design_pio_ext_if bus_a ();
    hps_design_pio_ext_if bus_b ();
    assign bus_a.address = address;
    assign bus_a.chipselect = chipselect;
    assign bus_a.write_n = write_n;
    assign bus_a.writedata = writedata;
    assign bus_b.address = address;
    assign bus_b.chipselect = chipselect;
    assign bus_b.write_n = write_n;
    assign bus_b.writedata = writedata;
    hps_design_pio_ext #(.WIDTH(8), .RESET_VALUE(8'h00), .EDGE_TYPE(0), .IRQ_MODE(1)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave), .in_port(in_port),
        .out_port(out_a), .out_en(oe_a), .irq(irq_a));
    hps_design_pio_ext #(.WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(1), .IRQ_MODE(0)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave), .in_port(in_port),
        .out_port(out_b), .out_en(oe_b), .irq(irq_b));
    always #5 clk = ~clk;
    // model: per-variant register file plus a pin history (h0 newest .. h2 oldest)
    localparam logic [7:0] RV [2] = '{8'h00, 8'hA5};
    localparam int         ET [2] = '{0, 1};
    localparam int         IM [2] = '{1, 0};
    logic [7:0] m_data [2], m_dir [2], m_mask [2], m_cap [2], h0 [2], h1 [2], h2 [2];
    logic       m_irq [2];
    logic       m_valid = 0;
    logic       we;
    assign we = chipselect & ~write_n;
    function automatic logic [7:0] edg(input int et, input logic [7:0] now, input logic [7:0] was);
        return et == 0 ? now & ~was : et == 1 ? ~now & was : now ^ was;
    endfunction
    always @(posedge clk) begin
        if (reset) m_valid <= 1;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_data[k] <= RV[k]; m_dir[k] <= 0; m_mask[k] <= 0; m_cap[k] <= 0;
                h0[k] <= 0; h1[k] <= 0; h2[k] <= 0; m_irq[k] <= 0;
            end else begin
                m_irq[k] <= IM[k] == 1 ? |(m_cap[k] & m_mask[k]) : |(h1[k] & ~m_dir[k] & m_mask[k]);
                m_cap[k] <= (m_cap[k] & ~(we && address == 3 ? writedata[7:0] : 8'h00))
                            | (edg(ET[k], h1[k], h2[k]) & ~m_dir[k]);
                if (we && address == 0) m_data[k] <= writedata[7:0];
                if (we && address == 4) m_data[k] <= m_data[k] | writedata[7:0];
                if (we && address == 5) m_data[k] <= m_data[k] & ~writedata[7:0];
                if (we && address == 1) m_dir[k] <= writedata[7:0];
                if (we && address == 2) m_mask[k] <= writedata[7:0];
                h0[k] <= in_port; h1[k] <= h0[k]; h2[k] <= h1[k];
            end
        end
    end
    function automatic logic [31:0] exp_rd(input int k);
        if (!chipselect) return 0;
        case (address)
            3'd0: return {24'b0, (m_dir[k] & m_data[k]) | (~m_dir[k] & h1[k])};
            3'd1: return {24'b0, m_dir[k]};
            3'd2: return {24'b0, m_mask[k]};
            3'd3: return {24'b0, m_cap[k]};
            default: return 0;
        endcase
    endfunction
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask
    always @(negedge clk) if (m_valid) begin
        check("a.out_port", {24'b0, out_a}, {24'b0, m_data[0]});
        check("a.out_en", {24'b0, oe_a}, {24'b0, m_dir[0]});
        check("a.irq", {31'b0, irq_a}, {31'b0, m_irq[0]});
        check("a.readdata", bus_a.readdata, exp_rd(0));
        check("b.out_port", {24'b0, out_b}, {24'b0, m_data[1]});
        check("b.out_en", {24'b0, oe_b}, {24'b0, m_dir[1]});
        check("b.irq", {31'b0, irq_b}, {31'b0, m_irq[1]});
        check("b.readdata", bus_b.readdata, exp_rd(1));
    end
    task automatic tick; @(posedge clk); #2; endtask
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1; write_n = 0; address = a; writedata = d;
        tick;
        chipselect = 0; write_n = 1;
    endtask
    task automatic rd(input logic [2:0] a, input logic [7:0] e, input string nm);
        chipselect = 1; address = a; #1;
        check(nm, bus_a.readdata, {24'b0, e});
        chipselect = 0;
    endtask
    initial begin
        tick; tick;
        reset = 0;
        rd(0, 8'h00, "rst.rd0"); rd(1, 8'h00, "rst.rd1"); rd(2, 8'h00, "rst.rd2"); rd(3, 8'h00, "rst.rd3");
        check("rst.out_en", {24'b0, oe_a}, 32'h0);
        check("rst.irq", {31'b0, irq_a}, 32'h0);
        check("rst.b_out", {24'b0, out_b}, 32'hA5);
        wr(1, 32'hFF); wr(0, 32'hFFFF_FF5A); wr(4, 32'h81); wr(5, 32'h02);
        check("setclr.out", {24'b0, out_a}, 32'hD9);
        rd(0, 8'hD9, "setclr.rd0");
        wr(1, 32'h00); wr(2, 32'h01);
        in_port = 8'h01;
        tick; tick; tick;
        rd(3, 8'h01, "edge.cap");
        check("edge.irq_early", {31'b0, irq_a}, 32'h0);
        tick;
        check("edge.irq", {31'b0, irq_a}, 32'h1);
        wr(3, 32'h01);
        tick;
        check("edge.irq_clr", {31'b0, irq_a}, 32'h0);
        in_port = 8'h05;
        tick; tick;
        wr(3, 32'h04);
        rd(3, 8'h04, "race.cap");
        wr(0, 32'hFF);
        in_port = 8'h00;
        repeat (4) tick;
        in_port = 8'h0F;
        repeat (4) tick;
        rd(3, 8'h0F, "pre_rst.cap");
        check("pre_rst.out", {24'b0, out_a}, 32'hFF);
        reset = 1; chipselect = 1; write_n = 0; address = 0; writedata = 32'h33;
        tick;
        reset = 0; chipselect = 0; write_n = 1;
        check("mid_rst.out", {24'b0, out_a}, 32'h00);
        check("mid_rst.b_out", {24'b0, out_b}, 32'hA5);
        check("mid_rst.irq", {31'b0, irq_a}, 32'h0);
        rd(3, 8'h00, "mid_rst.cap"); rd(1, 8'h00, "mid_rst.dir"); rd(2, 8'h00, "mid_rst.mask");
        tick; tick; tick;
        rd(3, 8'h0F, "post_rst.cap");
        in_port = 8'h00;
        repeat (4) tick;
        wr(3, 32'hFF); wr(2, 32'h10);
        in_port = 8'h10;
        tick; tick;
        check("lvl.irq_early", {31'b0, irq_b}, 32'h0);
        tick;
        check("lvl.irq_on", {31'b0, irq_b}, 32'h1);
        in_port = 8'h00;
        tick; tick;
        check("lvl.irq_hold", {31'b0, irq_b}, 32'h1);
        tick;
        check("lvl.irq_off", {31'b0, irq_b}, 32'h0);
        wr(6, 32'hFF); wr(7, 32'hFF);
        check("rsv.out", {24'b0, out_a}, 32'h00);
        rd(0, 8'h00, "rsv.rd0"); rd(4, 8'h00, "rsv.rd4"); rd(7, 8'h00, "rsv.rd7");
        wr(1, 32'h3C);
        rd(1, 8'h3C, "dir.rd1");
        check("dir.out_en", {24'b0, oe_a}, 32'h3C);
        address = 1; #1;
        check("nocs.rd", bus_a.readdata, 32'h0);
        repeat (2) tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
